// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a per-register
// busy scoreboard for RAW/WAW hazard detection. Optional forwarding: REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic                  busy_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy_b,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] issue_dst,
    output logic                  stall
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic                  wr_valid;

    assign wr_valid = we && (wr_addr != '0);

    // WAW guard: a pending destination blocks issue unless it retires this same cycle
    assign stall = issue && busy_q[issue_dst] && !(we && (wr_addr == issue_dst));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_valid) begin
            regs_d[wr_addr] = wr_data;
        end
        if (we) begin
            busy_d[wr_addr] = 1'b0;
        end
        // Issue is applied after writeback so it wins on a shared register
        if (issue && (issue_dst != '0) && !stall) begin
            busy_d[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        busy_a    = busy_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        busy_b    = busy_q[rd_addr_b];
        if (wr_valid && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            busy_a    = 1'b0;
        end
        if (wr_valid && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            busy_b    = 1'b0;
        end
    end
`else
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        busy_a    = busy_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        busy_b    = busy_q[rd_addr_b];
    end
`endif

endmodule
